// File: rtl/port_priority_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : port_priority_arbiter
// Purpose : One-of-seven FIFO scheduler: priority first, round-robin tie-break,
//           age-based anti-starvation boost, registered select for readout.
// Rev     : 1.0  initial release
// ============================================================================
module port_priority_arbiter #(
  parameter int NUM_PORTS      = 7,
  parameter int PRIORITY_WIDTH = 8,
  parameter int AGE_WIDTH      = 4,
  parameter int AGE_LIMIT      = 15
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                req,
  input  logic [NUM_PORTS*PRIORITY_WIDTH-1:0] prio,
  input  logic                                out_stall,
  output logic [NUM_PORTS-1:0]                grant,
  output logic                                sel_valid,
  output logic [2:0]                          sel_index,
  output logic [2:0]                          rr_ptr
);

  logic [AGE_WIDTH-1:0]    r_age [NUM_PORTS];
  logic                    r_sel_valid;
  logic [2:0]              r_sel_index;
  logic [2:0]              r_rr_ptr;

  logic [PRIORITY_WIDTH:0] w_key [NUM_PORTS];
  logic [PRIORITY_WIDTH:0] w_best_key;
  logic                    w_found;
  logic [2:0]              w_win;
  logic [2:0]              w_idx;
  logic [3:0]              w_sum;
  logic                    w_grant_en;
  logic [NUM_PORTS-1:0]    w_grant;

  // Saturated age lifts the boost bit above every priority value.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_key
    assign w_key[g] = {(r_age[g] == AGE_WIDTH'(AGE_LIMIT)),
                       prio[g*PRIORITY_WIDTH +: PRIORITY_WIDTH]};
  end

  // Scan in round-robin order; strict '>' keeps the first tied candidate.
  always_comb begin
    w_found    = 1'b0;
    w_best_key = '0;
    w_win      = '0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 4'(k);
      if (w_sum >= 4'(NUM_PORTS)) begin
        w_sum = w_sum - 4'(NUM_PORTS);
      end
      w_idx = w_sum[2:0];
      if (req[w_idx] && (!w_found || (w_key[w_idx] > w_best_key))) begin
        w_found    = 1'b1;
        w_best_key = w_key[w_idx];
        w_win      = w_idx;
      end
    end
  end

  assign w_grant_en = rst & ~out_stall & (|req);
  assign w_grant    = w_grant_en ? (NUM_PORTS'(1) << w_win) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sel_valid <= 1'b0;
      r_sel_index <= '0;
      r_rr_ptr    <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_age[i] <= '0;
      end
    end else if (out_stall) begin
      r_sel_valid <= 1'b0;
    end else begin
      r_sel_valid <= |w_grant;
      if (w_grant_en) begin
        r_sel_index <= w_win;
        r_rr_ptr    <= (w_win == 3'(NUM_PORTS-1)) ? 3'd0 : w_win + 3'd1;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!req[i] || w_grant[i]) begin
          r_age[i] <= '0;
        end else if (r_age[i] != AGE_WIDTH'(AGE_LIMIT)) begin
          r_age[i] <= r_age[i] + AGE_WIDTH'(1);
        end
      end
    end
  end

  assign grant     = w_grant;
  assign sel_valid = r_sel_valid;
  assign sel_index = r_sel_index;
  assign rr_ptr    = r_rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_port_priority_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_port_priority_arbiter
// Purpose : Scoreboard bench: a reference model queues expected grant and
//           registered outputs; independent monitors pop and compare.
// Rev     : 1.0  initial release
// ============================================================================
module tb_port_priority_arbiter;

  localparam int NP = 7;
  localparam int LIM = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    req;
  logic [55:0]   prio;
  logic          out_stall;
  logic [6:0]    grant;
  logic          sel_valid;
  logic [2:0]    sel_index;
  logic [2:0]    rr_ptr;

  port_priority_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .prio      (prio),
    .out_stall (out_stall),
    .grant     (grant),
    .sel_valid (sel_valid),
    .sel_index (sel_index),
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  logic [6:0] q_grant [$];
  logic [6:0] q_reg   [$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_age [NP];
  int m_rr = 0;
  int m_si = 0;
  bit m_sv = 1'b0;

  function automatic int eff_key(input int i, input logic [55:0] pr);
    return ((m_age[i] == LIM) ? 256 : 0) + int'(pr[8*i +: 8]);
  endfunction

  // Drive one cycle's inputs at the falling edge and queue the expectations.
  task automatic step(input logic r, input logic [6:0] rq, input logic [55:0] pr,
                      input logic st);
    int best;
    int win;
    logic [6:0] eg;
    @(negedge clk);
    rst = r; req = rq; prio = pr; out_stall = st;
    eg  = '0;
    win = -1;
    if (r && !st && rq != 0) begin
      best = -1;
      for (int i = 0; i < NP; i++)
        if (rq[i] && eff_key(i, pr) > best) best = eff_key(i, pr);
      for (int k = 0; k < NP; k++) begin
        int idx;
        idx = (m_rr + k) % NP;
        if (win < 0 && rq[idx] && eff_key(idx, pr) == best) win = idx;
      end
      eg[win] = 1'b1;
    end
    q_grant.push_back(eg);
    if (!r) begin
      m_sv = 0; m_si = 0; m_rr = 0;
      for (int i = 0; i < NP; i++) m_age[i] = 0;
    end else if (st) begin
      m_sv = 0;
    end else begin
      m_sv = (win >= 0);
      if (win >= 0) begin
        m_si = win;
        m_rr = (win + 1) % NP;
      end
      for (int i = 0; i < NP; i++) begin
        if (!rq[i] || i == win) m_age[i] = 0;
        else if (m_age[i] < LIM) m_age[i] = m_age[i] + 1;
      end
    end
    q_reg.push_back({m_sv, 3'(m_si), 3'(m_rr)});
  endtask

  // Grant monitor: combinational output, sampled mid low phase.
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (q_grant.size() > 0) begin
        e = q_grant.pop_front();
        n_cmp++;
        if (grant !== e) begin
          n_err++;
          $display("FAIL grant: got %b expected %b at %0t", grant, e, $time);
        end
      end
    end
  end

  // Registered-output monitor, sampled just after the rising edge.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q_reg.size() > 0) begin
        e = q_reg.pop_front();
        n_cmp++;
        if ({sel_valid, sel_index, rr_ptr} !== e) begin
          n_err++;
          $display("FAIL regs: got valid=%b index=%0d rr=%0d expected valid=%b index=%0d rr=%0d at %0t",
                   sel_valid, sel_index, rr_ptr, e[6], e[5:3], e[2:0], $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] p;
    logic [6:0]  rq;
    for (int i = 0; i < NP; i++) m_age[i] = 0;
    rst = 1'b0; req = '0; prio = '0; out_stall = 1'b0;

    // Reset with all ports requesting
    repeat (2) step(1'b0, 7'h7F, {7{8'd5}}, 1'b0);

    // Round-robin on equal priorities, including wrap 6 -> 0
    repeat (9) step(1'b1, 7'h7F, {7{8'd5}}, 1'b0);

    // Strict priority
    p = '0; p[8*1 +: 8] = 8'd3; p[8*3 +: 8] = 8'd9;
    step(1'b1, 7'b0001010, p, 1'b0);
    step(1'b1, 7'b0000000, p, 1'b0);

    // Starvation boost: port 2 low prio versus port 5 high prio
    p = '0; p[8*2 +: 8] = 8'd1; p[8*5 +: 8] = 8'd200;
    repeat (20) step(1'b1, 7'b0100100, p, 1'b0);

    // Stall with everyone requesting, then resume
    repeat (3) step(1'b1, 7'h7F, {7{8'd5}}, 1'b1);
    repeat (4) step(1'b1, 7'h7F, {7{8'd5}}, 1'b0);

    // Empty and single-requester boundary
    repeat (2) step(1'b1, 7'h00, {7{8'd5}}, 1'b0);
    step(1'b1, 7'b1000000, {7{8'd0}}, 1'b0);
    step(1'b1, 7'b1000000, {7{8'd0}}, 1'b0);

    // Reset asserted during a stall
    step(1'b1, 7'h7F, {7{8'd5}}, 1'b1);
    step(1'b0, 7'h7F, {7{8'd5}}, 1'b1);
    step(1'b1, 7'h7F, {7{8'd5}}, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rq = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom);
      for (int i = 0; i < NP; i++)
        p[8*i +: 8] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 2))
                                                  : 8'($urandom_range(0, 255));
      step(($urandom_range(0, 99) != 0), rq, p, ($urandom_range(0, 4) == 0));
    end

    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if (q_grant.size() != 0 || q_reg.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q_grant.size(), q_reg.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/port_priority_arbiter.md
Name: port_priority_arbiter

Overview:
- Scheduler that shares the single switch output pipeline among the 7 input FIFOs (local, yneg, ypos, xpos, xneg, zpos, zneg).
- Selects one non-empty FIFO per cycle by packet priority, with round-robin tie-breaking and an age-based anti-starvation boost.
- Drives the FIFO consume strobes and a registered select index for the downstream reduction-read stage.
- Honours the downstream stall.

Parameters:
- NumPorts, 7, number of requesting FIFOs; index width is fixed at 3 bits.
- PriorityWidth, 8, width of each packet priority field.
- AgeWidth, 4, width of the per-port starvation counter.
- AgeLimit, 15, age value at which a port is boosted; must be at most 2^AgeWidth-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-low.
- req  input  7  bit i = FIFO i non-empty.
- prio  input  56  priority of the head packet of FIFO i, at bits [8i+7:8i].
- out_stall  input  1  downstream pipeline stall.
- grant  output  7  one-hot consume strobe to the FIFOs; combinational.
- sel_valid  output  1  registered; a packet was granted in the previous cycle.
- sel_index  output  3  registered index (0-6) of the previous cycle's grant.
- rr_ptr  output  3  current round-robin start pointer (debug/verification).

Behaviour:
- Reset (rst=0 at posedge):
  - sel_valid=0, sel_index=0, rr_ptr=0, all age counters=0.
  - While rst=0, grant=0 regardless of req.
- Effective priority of port i: {boost_i, prio_i}, where boost_i = (age_i == AgeLimit).
  - Any boosted requester beats every non-boosted one.
- Candidates are the ports with req_i=1. The winner has the highest effective priority.
- Ties are broken by round-robin order: scan rr_ptr, rr_ptr+1, ... mod 7; the first tied candidate wins.
- grant:
  - Exactly one bit is set iff out_stall=0, rst=1 and req≠0; otherwise grant=0.
  - grant never selects a port with req_i=0.
  - Same-cycle (zero-latency) path from req/prio/out_stall to grant.
- sel_valid / sel_index:
  - On each posedge with rst=1: sel_valid <= |grant, and sel_index <= winner index when a grant is made.
  - sel_index holds its old value when there is no grant.
  - Latency is 1 cycle from grant to sel_valid.
- rr_ptr:
  - On a grant to port w, rr_ptr <= (w==6) ? 0 : w+1.
  - Unchanged otherwise.
- Age counters, per port per posedge, first match applies:
  - out_stall=1: hold all counters, rr_ptr and sel_index; sel_valid <= 0.
  - req_i=0: age_i <= 0.
  - port i granted: age_i <= 0.
  - req_i=1 and another port granted: age_i <= min(age_i+1, AgeLimit), saturating, no wrap.
  - req≠0 but no grant cannot occur without a stall.
- Simultaneous events:
  - Multiple ports boosted: they compare on prio; ties resolve by round-robin.
  - req deasserting on the same cycle as a boost: that port's age is cleared.
- Reset mid-operation: asserting rst during a stall or a burst clears all state next edge; grant drops immediately.
- Priority value 0 is legal and competes normally.
- No internal FIFO; the block does not register data payloads.

Test Plan:
- Reset: rst=0 for 2 cycles with req=7'h7F → grant=0, sel_valid=0, rr_ptr=0; release → grant asserted in the first cycle with rst=1.
- Strict priority: req=7'b0001010, prio[1]=3, prio[3]=9 → grant=7'b0001000; next cycle sel_valid=1, sel_index=3, rr_ptr=4.
- Round-robin tie: req=7'h7F, all prio=5, no stall for 7 cycles from reset → grant order 0,1,2,3,4,5,6, then 0; rr_ptr wraps from 6 to 0.
- Starvation boost: port 2 prio=1 and port 5 prio=200, both requesting continuously → port 5 wins 15 cycles while age_2 reaches 15; cycle 16 grants port 2; age_2 returns to 0.
- Stall: out_stall=1 for 3 cycles with req=7'h7F → grant=0 and sel_valid=0 on each; rr_ptr and ages unchanged; on release the previous winner order resumes.
- Empty/boundary: req=0 → grant=0, sel_valid falls to 0 next cycle, ages clear; single req=7'b1000000 → grant=7'b1000000, rr_ptr=0 next cycle.
